// File: rtl/dac_pkg.sv
// Shared types and constants for the serial DAC sample scheduler.
// The driver frames each sample as a 4-bit command followed by DW data bits.
package dac_pkg;

    localparam int         DAC_DW    = 12;
    localparam logic [3:0] DAC_CMD   = 4'b1100;
    localparam int         FRAME_LEN = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_GAP
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts one past the last granted channel and wraps modulo NCH.
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] last,
    output logic [NCH-1:0]         grant,
    output logic [$clog2(NCH)-1:0] idx,
    output logic                   valid
);

    localparam int IW = $clog2(NCH);

    logic [IW-1:0] cand;

    // NOTE: every output of a combinational block gets a default first; a path that skips an assignment would infer a latch.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NCH; i++) begin
            cand = IW'((int'(last) + i) % NCH);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/dac_sample_scheduler.sv
// Shares one serial DAC driver among NCH sample producers: round-robin grant,
// two-cycle start pulse, CS frame tracking, start spacing and frame timeout.
module dac_sample_scheduler
    import dac_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = DAC_DW,
    parameter int PERIOD  = 24,
    parameter int TIMEOUT = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*DW-1:0]      data,
    output logic [NCH-1:0]         ack,
    output logic                   dac_start,
    output logic [DW-1:0]          dac_data,
    output logic [$clog2(NCH)-1:0] dac_chan,
    input  logic                   dac_cs,
    output logic                   busy,
    output logic                   err
);

    localparam int IW = $clog2(NCH);
    localparam int SW = $clog2(PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [SW-1:0] SPACE_MAX  = SW'(PERIOD);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] START_LAST = TW'(1);

    state_t          state, state_d;
    logic [IW-1:0]   last;
    logic [NCH-1:0]  arb_grant;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;
    logic [DW-1:0]   sel_data;
    logic [SW-1:0]   space_cnt;
    logic [TW-1:0]   to_cnt;
    logic            counting;
    logic            grant_load;
    logic [NCH-1:0]  ack_d;
    logic            start_d;
    logic            err_d;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req   (req),
        .last  (last),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign sel_data = data[arb_idx*DW +: DW];
    assign counting = (state == ST_START) || (state == ST_WAIT_LOW) || (state == ST_WAIT_HIGH);
    assign busy     = (state != ST_IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    // The timeout counter doubles as the START phase counter: it is 0 then 1.
    always_comb begin
        state_d    = state;
        grant_load = 1'b0;
        ack_d      = '0;
        start_d    = 1'b0;
        err_d      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid && space_cnt == SPACE_MAX) begin
                    grant_load = 1'b1;
                    ack_d      = arb_grant;
                    start_d    = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (to_cnt == START_LAST) state_d = ST_WAIT_LOW;
                else                      start_d = 1'b1;
            end
            ST_WAIT_LOW: begin
                if (to_cnt == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                end else if (!dac_cs) begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            ST_WAIT_HIGH: begin
                if (dac_cs) begin
                    state_d = ST_GAP;
                end else if (to_cnt == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (space_cnt == SPACE_MAX) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the sample and channel registers are reset too, because their reset values are visible at the driver interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack       <= '0;
            dac_start <= 1'b0;
            err       <= 1'b0;
            dac_data  <= '0;
            dac_chan  <= '0;
            last      <= IW'(NCH - 1);
            space_cnt <= SPACE_MAX;
            to_cnt    <= '0;
        end else begin
            ack       <= ack_d;
            dac_start <= start_d;
            err       <= err_d;
            if (grant_load) begin
                dac_data  <= sel_data;
                dac_chan  <= arb_idx;
                last      <= arb_idx;
                space_cnt <= SW'(1);
                to_cnt    <= '0;
            end else begin
                if (space_cnt != SPACE_MAX) space_cnt <= space_cnt + SW'(1);
                if (counting)               to_cnt    <= to_cnt + TW'(1);
            end
        end
    end

endmodule
